// File: rtl/pack_recv.sv
// pack_recv: receive side of the orbtrace packet link. Acquires FF FF FF 7F
// sync, rebuilds 16-byte frames and replays each one as eight 16-bit words.
// Ports:
//   clk, rst_n                clock, async active-low reset
//   DataVal[7:0], DataReady   incoming byte and its one-cycle strobe
//   DataNext                  byte request, high from first clock after reset
//   sync                      frame alignment held
//   WdAvail, PacketWd[15:0]   word strobe and reassembled word
//   PacketReset               pulse on every detected sync sequence
//   SyncLost                  pulse when sync drops on timeout
module pack_recv #(
  parameter int SYNC_TIMEOUT_LOG2 = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  DataVal,
  input  logic        DataReady,
  output logic        DataNext,
  output logic        sync,
  output logic        WdAvail,
  output logic [15:0] PacketWd,
  output logic        PacketReset,
  output logic        SyncLost
);

  localparam int TW = SYNC_TIMEOUT_LOG2;
  // Last count before the all-ones limit: the drop lands
  // on the clock after the counter reaches the limit.
  localparam logic [TW-1:0] TMO_LAST = {{(TW-1){1'b1}}, 1'b0};

  typedef enum logic {
    IDLE,
    EMIT
  } emitState_t;

  emitState_t  state;
  emitState_t  nextState;

  logic [23:0] hist;
  logic [3:0]  byteCnt;
  logic [15:0] fillBuf [8];
  logic [15:0] emitBuf [8];
  logic [2:0]  emitIdx;
  logic [TW-1:0] tmoCnt;

  logic        match;
  logic        fillEn;
  logic        frameDone;
  logic        timeout;
  logic        wdNext;
  logic [15:0] pwNext;

  // Match uses the three stored bytes plus the byte arriving now.
  assign match = DataReady
              && (DataVal == 8'h7F)
              && (hist == 24'hFFFFFF);

  assign fillEn    = sync && DataReady && !match;
  assign frameDone = fillEn && (byteCnt == 4'hF);
  assign timeout   = sync && !match && (tmoCnt == TMO_LAST);

  // Emitter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Emitter next state; a new frame always restarts at word 0
  always_comb begin
    nextState = state;
    if (frameDone)
      nextState = EMIT;
    else if (state == EMIT && emitIdx == 3'd7)
      nextState = IDLE;
  end

  // Emitter outputs; word 0 comes straight from the fill buffer
  always_comb begin
    wdNext = 1'b0;
    pwNext = PacketWd;
    if (frameDone) begin
      wdNext = 1'b1;
      pwNext = fillBuf[0];
    end else if (state == EMIT) begin
      wdNext = 1'b1;
      pwNext = emitBuf[emitIdx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DataNext    <= 1'b0;
      sync        <= 1'b0;
      WdAvail     <= 1'b0;
      PacketWd    <= '0;
      PacketReset <= 1'b0;
      SyncLost    <= 1'b0;
      hist        <= '0;
      byteCnt     <= '0;
      emitIdx     <= '0;
      tmoCnt      <= '0;
      for (int i = 0; i < 8; i++) begin
        fillBuf[i] <= '0;
        emitBuf[i] <= '0;
      end
    end else begin
      DataNext    <= 1'b1;
      WdAvail     <= wdNext;
      PacketWd    <= pwNext;
      PacketReset <= match;
      SyncLost    <= timeout;

      if (DataReady)
        hist <= {hist[15:0], DataVal};

      if (fillEn) begin
        if (byteCnt[0])
          fillBuf[byteCnt[3:1]][15:8] <= DataVal;
        else
          fillBuf[byteCnt[3:1]][7:0] <= DataVal;
        byteCnt <= byteCnt + 4'd1;
      end

      if (frameDone) begin
        for (int i = 0; i < 7; i++)
          emitBuf[i] <= fillBuf[i];
        emitBuf[7] <= {DataVal, fillBuf[7][7:0]};
        emitIdx    <= 3'd1;
      end else if (state == EMIT) begin
        emitIdx <= emitIdx + 3'd1;
      end

      if (match || timeout)
        byteCnt <= '0;

      if (match)
        sync <= 1'b1;
      else if (timeout)
        sync <= 1'b0;

      if (match || !sync || timeout)
        tmoCnt <= '0;
      else
        tmoCnt <= tmoCnt + TW'(1);
    end
  end

endmodule

// File: doc/pack_recv.md
# pack_recv

Receive-side counterpart of the orbtrace packet sender. Consumes the byte stream that the sender emits: 16-byte frames of eight little-endian 16-bit words, with `FF FF FF 7F` keepalive sync sequences inserted only at frame boundaries. It acquires and tracks sync, realigns on every sync sequence, and reassembles complete frames. Each complete frame is re-emitted as eight consecutive 16-bit words, so on-chip loopback and bench checkers see the same word/packet interface the sender consumes.

## Interface
- `SYNC_TIMEOUT_LOG2`, default 18: sync is declared lost after 2^SYNC_TIMEOUT_LOG2 − 1 clocks without a sync sequence. Must exceed the sender keepalive interval of 2^17.
- `clk` input 1: system clock. One clock; everything is in this domain.
- `rst_n` input 1: reset, asynchronous, active-low.
- `DataVal` input 8: byte from the sender; valid while `DataReady` is high.
- `DataReady` input 1: one-cycle byte strobe.
- `DataNext` output 1: byte request to the sender.
- `sync` output 1: frame alignment is held.
- `WdAvail` output 1: one-cycle strobe; `PacketWd` is valid.
- `PacketWd` output 16: reassembled word.
- `PacketReset` output 1: one-cycle pulse when a sync sequence is detected; any partial frame is discarded.
- `SyncLost` output 1: one-cycle pulse when `sync` falls because of timeout.

## Operation
- Reset values: `DataNext`=0, `sync`=0, `WdAvail`=0, `PacketWd`=0, `PacketReset`=0, `SyncLost`=0. Byte counter, shift history, timeout counter and emit state are also cleared.
- `DataNext` is 1 from the first clock after reset release and stays 1. The block never back-pressures.
- Byte accept: on any clock with `DataReady`=1, `DataVal` is taken, regardless of `DataNext` or sync state.
- Sync detector: a 4-byte history of accepted bytes. A match is the last four bytes equal to `FF`,`FF`,`FF`,`7F` in arrival order. A match is checked at every byte position, in or out of sync. A data pattern matching it is treated as sync.
- On a match:
  - `PacketReset` pulses.
  - `sync` is set.
  - The byte counter is set to 0, so the next byte is frame byte 0.
  - The partial frame buffer is discarded; the matching bytes never reach `PacketWd`.
  - The timeout counter is cleared.
- Frame fill, while `sync`=1 and there is no match:
  - Byte n (0..15) goes into fill-buffer word n/2.
  - Even n is written to bits [7:0], odd n to bits [15:8].
  - The counter wraps 15 → 0.
- On byte 15 the fill buffer is copied to the emit buffer and the emitter starts. The emitter is a two-state machine:
  - IDLE → EMIT on frame complete.
  - EMIT outputs words 0..7 on eight consecutive clocks with `WdAvail`=1, then returns to IDLE.
- The sender delivers at most one byte per 2 clocks, so the next frame completes at least 31 clocks later and the emitter is always IDLE by then.
- A frame completing while EMIT is still active is a protocol violation. The new frame replaces the emit buffer and the emitter restarts at word 0.
- A match during EMIT does not stop emission, because that frame was already complete. `PacketReset` and `WdAvail` may be high on the same clock.
- While `sync`=0, accepted bytes only feed the sync detector.
- Timeout:
  - While `sync`=1, the counter increments every clock and is cleared by a match.
  - On reaching 2^SYNC_TIMEOUT_LOG2 − 1: `sync` is cleared, `SyncLost` pulses, and the partial frame is discarded. A running emission completes.
  - While `sync`=0, the counter is held at 0.
- Asynchronous reset mid-frame or mid-emit: all state clears immediately, and no `WdAvail` is emitted after `rst_n` rises until a new sync and a full frame arrive.

## Timing
- All outputs are registered.
- `7F` of a sync accepted on clock t: `PacketReset`=1 and `sync`=1 at t+1.
- Byte 15 accepted on clock t: word k is on `PacketWd` with `WdAvail`=1 at t+1+k, for k=0..7. Latency from last byte to first word is 1 clock; to last word, 8 clocks.
- Timeout is reached at clock t: `sync`=0 and `SyncLost`=1 at t+1.
- `PacketWd` holds its last value when `WdAvail`=0.

## Test plan
- Idle after reset with no bytes -> `DataNext`=1 from the first clock after release; `sync`=0, `WdAvail`=0 indefinitely.
- Sync detection: send `FF FF FF 7F`, then bytes `00`..`0F` at one per 2 clocks -> `PacketReset` 1 clock after `7F`; after `0F`, eight `WdAvail` strobes with `PacketWd` = `0100`,`0302`,…,`0F0E`.
- Data before sync: `12 34 FF FF FF 7F` then a 16-byte frame -> only the post-sync frame is emitted; `12`/`34` never appear on `PacketWd`.
- Mid-frame resync: sync, 10 data bytes, sync again, 16 bytes `A0`..`AF` -> exactly 8 words `A1A0`..`AFAE`; two `PacketReset` pulses; the 10 bytes are dropped.
- Timeout with `SYNC_TIMEOUT_LOG2`=6: sync, then 5 bytes, then silence -> `SyncLost` pulse and `sync`=0 63 clocks after the match; a later frame without sync yields no `WdAvail`.
- Reset mid-emit: drop `rst_n` on the 3rd `WdAvail` -> outputs zero immediately; no further `WdAvail` until sync plus 16 bytes.
